// File: rtl/retire_trace_packer.sv
// retire_trace_packer
//
// Captures one record per retired instruction (opId, PC, register write
// enable/index/value) into a small FIFO and serializes each record into a
// fixed 12-byte frame on a ready/valid byte stream feeding the trace UART.
//
// Frame layout (byte 0 first):
//   0      : 0xA5 sync
//   1      : {regWE, 2'b00, regIndex}
//   2..5   : pc, little-endian
//   6..9   : value, little-endian
//   10..11 : opId, little-endian
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   retireValid           one instruction retires this cycle
//   retirePc              PC of the retiring instruction
//   retireRegWriteEnable  instruction writes an integer register
//   retireRegIndex        destination register index
//   retireRegValue        value written
//   outValid/outData      trace byte stream, accepted on outValid && outReady
//   outReady              consumer ready
//   dropCount             saturating count of records lost to a full FIFO
//   overflow              sticky, set on the first drop
//   busy                  FIFO non-empty or serializer mid-frame
module retire_trace_packer #(
    parameter int FifoDepth      = 16,
    parameter int DropCountWidth = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      retireValid,
    input  logic [31:0]               retirePc,
    input  logic                      retireRegWriteEnable,
    input  logic [4:0]                retireRegIndex,
    input  logic [31:0]               retireRegValue,
    output logic                      outValid,
    output logic [7:0]                outData,
    input  logic                      outReady,
    output logic [DropCountWidth-1:0] dropCount,
    output logic                      overflow,
    output logic                      busy
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;
    localparam int RecW = 86;
    localparam logic [CntW-1:0] FULL_CNT = CntW'(FifoDepth);

    // Record bit positions
    localparam int OP_LSB  = 70;
    localparam int PC_LSB  = 38;
    localparam int WE_BIT  = 37;
    localparam int IDX_LSB = 32;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    function automatic logic [DropCountWidth-1:0] sat_inc(
        input logic [DropCountWidth-1:0] v
    );
        return (&v) ? v : v + DropCountWidth'(1);
    endfunction

    state_t            state;
    state_t            state_next;
    logic [3:0]        byte_idx;
    logic [3:0]        byte_idx_next;
    logic              pop;

    logic [RecW-1:0]   mem [FifoDepth];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [CntW-1:0]   count;
    logic              full;
    logic              push_ok;
    logic              drop;
    logic [15:0]       op_id;

    logic [RecW-1:0]   rec_p0;
    logic [RecW-1:0]   frame_p1;
    logic [7:0]        frame_byte;

    // Stage 0: record capture and FIFO admission
    assign full    = (count == FULL_CNT);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = retireValid && (!full || pop);
    assign drop    = retireValid && full && !pop;

    assign rec_p0 = {op_id,
                     retirePc,
                     retireRegWriteEnable,
                     retireRegWriteEnable ? retireRegIndex : 5'd0,
                     retireRegWriteEnable ? retireRegValue : 32'd0};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rec_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            op_id     <= '0;
            dropCount <= '0;
            overflow  <= 1'b0;
        end else begin
            // opId advances on every retire, stored or not, so gaps reveal drops.
            if (retireValid) begin
                op_id <= op_id + 16'd1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                dropCount <= sat_inc(dropCount);
                overflow  <= 1'b1;
            end
        end
    end

    // Stage 1: frame register and byte serializer
    always_ff @(posedge clk) begin
        if (pop) begin
            frame_p1 <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_idx <= '0;
        end else begin
            state    <= state_next;
            byte_idx <= byte_idx_next;
        end
    end

    always_comb begin
        state_next    = state;
        byte_idx_next = byte_idx;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop           = 1'b1;
                    state_next    = SEND;
                    byte_idx_next = 4'd0;
                end
            end
            SEND: begin
                if (outReady) begin
                    if (byte_idx == 4'd11) begin
                        state_next    = IDLE;
                        byte_idx_next = 4'd0;
                    end else begin
                        byte_idx_next = byte_idx + 4'd1;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                byte_idx_next = 4'd0;
            end
        endcase
    end

    always_comb begin
        frame_byte = 8'h00;
        case (byte_idx)
            4'd0:    frame_byte = 8'hA5;
            4'd1:    frame_byte = {frame_p1[WE_BIT], 2'b00, frame_p1[IDX_LSB +: 5]};
            4'd2:    frame_byte = frame_p1[PC_LSB +: 8];
            4'd3:    frame_byte = frame_p1[PC_LSB + 8 +: 8];
            4'd4:    frame_byte = frame_p1[PC_LSB + 16 +: 8];
            4'd5:    frame_byte = frame_p1[PC_LSB + 24 +: 8];
            4'd6:    frame_byte = frame_p1[7:0];
            4'd7:    frame_byte = frame_p1[15:8];
            4'd8:    frame_byte = frame_p1[23:16];
            4'd9:    frame_byte = frame_p1[31:24];
            4'd10:   frame_byte = frame_p1[OP_LSB +: 8];
            4'd11:   frame_byte = frame_p1[OP_LSB + 8 +: 8];
            default: frame_byte = 8'h00;
        endcase
    end

    // The frame register is not reset, so the byte is gated while idle.
    assign outValid = (state == SEND);
    assign outData  = (state == SEND) ? frame_byte : 8'h00;
    assign busy     = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_retire_trace_packer.sv
module tb_retire_trace_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        retireValid;
    logic [31:0] retirePc;
    logic        retireRegWriteEnable;
    logic [4:0]  retireRegIndex;
    logic [31:0] retireRegValue;
    logic        outValid;
    logic [7:0]  outData;
    logic        outReady;
    logic [15:0] dropCount;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    retire_trace_packer #(.FifoDepth(16), .DropCountWidth(16)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .retireValid          (retireValid),
        .retirePc             (retirePc),
        .retireRegWriteEnable (retireRegWriteEnable),
        .retireRegIndex       (retireRegIndex),
        .retireRegValue       (retireRegValue),
        .outValid             (outValid),
        .outData              (outData),
        .outReady             (outReady),
        .dropCount            (dropCount),
        .overflow             (overflow),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  idx;
        logic [31:0] pc;
        logic [31:0] val;
        logic [95:0] exp;   // byte 0 in the top byte
    } vec_t;

    vec_t tbl [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_retire(input logic we, input logic [4:0] idx,
                                input logic [31:0] pc, input logic [31:0] val);
        retireValid          = 1'b1;
        retireRegWriteEnable = we;
        retireRegIndex       = idx;
        retirePc             = pc;
        retireRegValue       = val;
    endtask

    task automatic send_and_check(input vec_t v, input string name);
        drive_retire(v.we, v.idx, v.pc, v.val);
        tick();
        retireValid = 1'b0;
        check($sformatf("%s_lat1_valid", name), 32'(outValid), 32'd0);
        check($sformatf("%s_busy_cap", name), 32'(busy), 32'd1);
        tick();
        for (int k = 0; k < 12; k++) begin
            check($sformatf("%s_valid%0d", name, k), 32'(outValid), 32'd1);
            check($sformatf("%s_byte%0d", name, k), 32'(outData), 32'(v.exp[95-8*k -: 8]));
            tick();
        end
        check($sformatf("%s_busy_end", name), 32'(busy), 32'd0);
        check($sformatf("%s_valid_end", name), 32'(outValid), 32'd0);
    endtask

    task automatic get_frame(output logic [95:0] f);
        int w;
        w = 0;
        f = '0;
        while (outValid !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        check("frame_start", 32'(outValid), 32'd1);
        for (int k = 0; k < 12; k++) begin
            check("frame_valid", 32'(outValid), 32'd1);
            f[95-8*k -: 8] = outData;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [95:0] f;
        vec_t        rv;

        tbl[0] = '{we: 1'b1, idx: 5'd5,  pc: 32'h80000004, val: 32'hDEADBEEF,
                   exp: 96'hA5_85_04_00_00_80_EF_BE_AD_DE_00_00};
        tbl[1] = '{we: 1'b0, idx: 5'd7,  pc: 32'h00001000, val: 32'h12345678,
                   exp: 96'hA5_00_00_10_00_00_00_00_00_00_01_00};
        tbl[2] = '{we: 1'b1, idx: 5'd0,  pc: 32'h12345678, val: 32'hCAFEF00D,
                   exp: 96'hA5_80_78_56_34_12_0D_F0_FE_CA_02_00};
        tbl[3] = '{we: 1'b1, idx: 5'd31, pc: 32'hFFFFFFFC, val: 32'h00000001,
                   exp: 96'hA5_9F_FC_FF_FF_FF_01_00_00_00_03_00};

        rst                  = 1'b1;
        retireValid          = 1'b0;
        retirePc             = '0;
        retireRegWriteEnable = 1'b0;
        retireRegIndex       = '0;
        retireRegValue       = '0;
        outReady             = 1'b1;
        tick();
        tick();
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_outData", 32'(outData), 32'd0);
        check("rst_dropCount", 32'(dropCount), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven single-record frames, opIds 0..3
        for (int i = 0; i < 4; i++) begin
            send_and_check(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-pressure at byteIndex=3, opId 4
        drive_retire(1'b1, 5'd2, 32'hAABBCCDD, 32'h11223344);
        tick();
        retireValid = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("stall_pre_byte", 32'(outData), 32'(k == 0 ? 8'hA5 : (k == 1 ? 8'h82 : 8'hDD)));
            tick();
        end
        outReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", 32'(outValid), 32'd1);
            check("stall_data", 32'(outData), 32'hCC);
            tick();
        end
        outReady = 1'b1;
        rv.exp = 96'hA5_82_DD_CC_BB_AA_44_33_22_11_04_00;
        for (int k = 3; k < 12; k++) begin
            check("stall_post_valid", 32'(outValid), 32'd1);
            check($sformatf("stall_post_byte%0d", k), 32'(outData), 32'(rv.exp[95-8*k -: 8]));
            tick();
        end
        check("stall_busy_end", 32'(busy), 32'd0);

        // Overflow: 20 retires with consumer stalled, from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        outReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_retire(1'b1, 5'(i), 32'h100 + 32'(i), 32'(i));
            tick();
        end
        retireValid = 1'b0;
        check("ovf_dropCount", 32'(dropCount), 32'd3);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_busy", 32'(busy), 32'd1);
        outReady = 1'b1;
        get_frame(f);
        check("ovf_f0_sync", 32'(f[95:88]), 32'hA5);
        check("ovf_f0_op", 32'(f[15:0]), 32'h0000);
        check("ovf_f0_pc0", 32'(f[79:72]), 32'h00);
        // Serializer is IDLE with 16 queued: this retire lands on the pop edge.
        drive_retire(1'b1, 5'd1, 32'h214, 32'h0);
        tick();
        retireValid = 1'b0;
        check("full_pop_dropCount", 32'(dropCount), 32'd3);
        for (int j = 1; j <= 16; j++) begin
            get_frame(f);
            check($sformatf("ovf_f%0d_op", j), 32'({f[7:0], f[15:8]}), 32'(j));
            check($sformatf("ovf_f%0d_pc0", j), 32'(f[79:72]), 32'(j));
        end
        get_frame(f);
        check("ovf_last_op", 32'({f[7:0], f[15:8]}), 32'd20);
        check("ovf_last_pc0", 32'(f[79:72]), 32'h14);
        check("ovf_last_pc1", 32'(f[71:64]), 32'h02);
        check("ovf_end_busy", 32'(busy), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset at byteIndex=6
        drive_retire(1'b1, 5'd1, 32'h1234, 32'h99);
        tick();
        retireValid = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
        end
        check("midrst_pre_byte6", 32'(outData), 32'h99);
        rst = 1'b1;
        tick();
        check("midrst_outValid", 32'(outValid), 32'd0);
        check("midrst_dropCount", 32'(dropCount), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        rv = '{we: 1'b1, idx: 5'd3, pc: 32'h40, val: 32'h55,
               exp: 96'hA5_83_40_00_00_00_55_00_00_00_00_00};
        send_and_check(rv, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/retire_trace_packer.md
Name: retire_trace_packer

Overview:
- Sits directly downstream of the core's register-write (retire) stage.
- Captures one record per retired instruction (PC, destination register write, op sequence number) into a record FIFO.
- Serializes each record into a fixed 12-byte frame on a ready/valid byte stream, which feeds the UART transmitter for on-board trace.
- Gives FPGA runs the same retire-order visibility that simulation trace dumps give.

Parameters:
- FifoDepth, 16, record FIFO entries; power of two, minimum 2.
- DropCountWidth, 16, width of the saturating dropped-record counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- retireValid  in  1  one instruction retires this cycle
- retirePc  in  32  PC of retiring instruction
- retireRegWriteEnable  in  1  instruction writes an integer register
- retireRegIndex  in  5  destination register index
- retireRegValue  in  32  value written
- outValid  out  1  outData holds a valid byte
- outData  out  8  trace byte
- outReady  in  1  consumer accepts byte when outValid && outReady
- dropCount  out  DropCountWidth  records lost to FIFO full, saturating
- overflow  out  1  sticky; set on first drop
- busy  out  1  FIFO non-empty or serializer not IDLE

Behaviour:
- Reset: all outputs 0; FIFO empty; opId=0; serializer IDLE. Reset mid-frame abandons the frame with no partial completion; outValid=0 the cycle after reset is sampled.
- opId: 16-bit counter; increments (wraps 0xFFFF->0) on every cycle with retireValid=1, whether the record is stored or dropped. Gaps in opId therefore expose drops.
- Record fields: opId value before the increment, retirePc, regWE, regIndex, and value. value = retireRegValue if regWE else 0. regIndex = retireRegIndex if regWE else 0. Index 0 with regWE=1 is recorded as given.
- Push: on retireValid, the record is written at the rising edge.
  - Accepted if count<FifoDepth, or if a pop occurs in the same cycle.
  - Otherwise dropped: dropCount += 1, saturating at all-ones; overflow <= 1.
- Pop: occurs only when the serializer is IDLE and the FIFO is non-empty (count>0 at cycle start). The head record loads into the frame register.
- Serializer states:
  - IDLE --(count>0)--> SEND, byteIndex=0; record popped on the same edge.
  - SEND: outValid=1, outData=frame[byteIndex].
    - On handshake: byteIndex+1.
    - Handshake on byteIndex=11: go to IDLE. This gives one bubble cycle between frames.
  - SEND without handshake: outData and byteIndex are held stable. outValid never drops mid-frame.
- Frame layout, byte order 0..11:
  - 0: 0xA5 sync.
  - 1: {regWE, 2'b00, regIndex[4:0]}.
  - 2-5: pc, little-endian.
  - 6-9: value, little-endian.
  - 10-11: opId, little-endian.
- Latency: retireValid at edge N with FIFO empty and serializer IDLE -> outValid=1 with byte 0xA5 in cycle N+2.
- Throughput: 13 cycles per frame with outReady held high. Sustained retire rates above 1/13 fill the FIFO and then drop.
- busy = (count!=0) || state!=IDLE.
- Pointers are log2(FifoDepth) bits and wrap naturally. count has one extra bit; full = count==FifoDepth.

Test Plan:
- Single retire, pc=0x80000004, regWE=1, idx=5, value=0xDEADBEEF, outReady=1 -> bytes A5 85 04 00 00 80 EF BE AD DE 00 00. First byte appears 2 cycles after capture; busy=0 after the last byte.
- Retire with regWE=0, idx=7, value=0x12345678 -> byte1=0x00, bytes 6-9 all 0x00.
- outReady held 0 for 5 cycles mid-frame at byteIndex=3 -> outValid stays 1, outData stays pc[15:8]. Frame resumes intact after release.
- outReady=0 with retireValid asserted for 20 consecutive cycles, FifoDepth=16.
  - 17 pushes succeed: the first record pops into the frame register, so the FIFO holds 16.
  - 3 records dropped; dropCount=3, overflow=1.
  - Emitted opIds: 0..16 with no gap, then 20 onward for subsequent retires.
- retireValid on the same cycle a pop occurs with FIFO full -> record accepted, dropCount unchanged.
- rst asserted at byteIndex=6 -> next cycle outValid=0, dropCount=0, overflow=0. The next retire produces a frame with opId=0.
